// File: rtl/tdm_pkg.sv
// Shared types for the 4-slot TDM receive path.
package tdm_pkg;
    localparam int SLOTS = 4;

    typedef logic [1:0] slot_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;
endpackage

// File: rtl/tdm_slot_ctrl.sv
// Frame alignment FSM and slot counter for the TDM demux.
//  state | meaning
//  IDLE  | unaligned, waiting for a beat with frame_sync
//  RUN   | aligned, slot_q is the slot of the next beat
module tdm_slot_ctrl
    import tdm_pkg::*;
#(
    parameter int SYNC_CHECK = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  din_valid,
    input  logic  frame_sync,
    output logic  wr_en,
    output slot_t wr_slot,
    output logic  frame_done,
    output logic  sync_err,
    output slot_t slot
);

    state_t state_q, state_d;
    slot_t  slot_q, slot_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        wr_en      = 1'b0;
        wr_slot    = '0;
        frame_done = 1'b0;
        sync_err   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (din_valid && frame_sync) begin
                    wr_en   = 1'b1;
                    wr_slot = '0;
                    slot_d  = slot_t'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (din_valid) begin
                    if (frame_sync && slot_q != '0) begin
                        // misplaced sync: restart the frame on this beat
                        sync_err = 1'b1;
                        wr_en    = 1'b1;
                        wr_slot  = '0;
                        slot_d   = slot_t'(1);
                    end else if (!frame_sync && slot_q == '0 && SYNC_CHECK != 0) begin
                        sync_err = 1'b1;
                        slot_d   = '0;
                        state_d  = IDLE;
                    end else begin
                        wr_en      = 1'b1;
                        wr_slot    = slot_q;
                        slot_d     = slot_q + slot_t'(1);
                        frame_done = (slot_q == slot_t'(SLOTS - 1));
                    end
                end
            end
            default: begin
                state_d = IDLE;
                slot_d  = '0;
            end
        endcase
    end

    assign slot = slot_q;

endmodule

// File: rtl/tdm_demux_1to4.sv
// Receive side of the 4-channel TDM link: steers beats to channel registers A..D.
// Optional TDM_DEMUX_SHADOW_EN: stage beats and update all channels together on frame completion.
module tdm_demux_1to4
    import tdm_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SYNC_CHECK = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] ch_a,
    output logic [WIDTH-1:0] ch_b,
    output logic [WIDTH-1:0] ch_c,
    output logic [WIDTH-1:0] ch_d,
    output logic [3:0]       ch_strobe,
    output logic             frame_valid,
    output logic             sync_err,
    output logic [1:0]       slot,
    output logic [CNT_W-1:0] frame_cnt
);

    logic  wr_en;
    slot_t wr_slot;
    logic  frame_done;
    logic  sync_err_c;
    slot_t slot_c;

    tdm_slot_ctrl #(
        .SYNC_CHECK (SYNC_CHECK)
    ) u_slot_ctrl (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .wr_en      (wr_en),
        .wr_slot    (wr_slot),
        .frame_done (frame_done),
        .sync_err   (sync_err_c),
        .slot       (slot_c)
    );

    logic [WIDTH-1:0] ch_q [SLOTS];
    logic [3:0]       strobe_q;
    logic             frame_valid_q;
    logic             sync_err_q;
    logic [CNT_W-1:0] frame_cnt_q;

`ifdef TDM_DEMUX_SHADOW_EN
    logic [WIDTH-1:0] stage_q [SLOTS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                ch_q[i]    <= '0;
                stage_q[i] <= '0;
            end
            strobe_q <= '0;
        end else begin
            strobe_q <= '0;
            if (wr_en) begin
                stage_q[wr_slot] <= din;
            end
            // last beat bypasses staging so all four channels land on the same edge
            if (frame_done) begin
                for (int i = 0; i < SLOTS - 1; i++) begin
                    ch_q[i] <= stage_q[i];
                end
                ch_q[SLOTS-1] <= din;
                strobe_q      <= 4'b1111;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                ch_q[i] <= '0;
            end
            strobe_q <= '0;
        end else begin
            strobe_q <= '0;
            if (wr_en) begin
                ch_q[wr_slot]     <= din;
                strobe_q[wr_slot] <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            frame_valid_q <= frame_done;
            sync_err_q    <= sync_err_c;
            if (frame_done) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign ch_a        = ch_q[0];
    assign ch_b        = ch_q[1];
    assign ch_c        = ch_q[2];
    assign ch_d        = ch_q[3];
    assign ch_strobe   = strobe_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign slot        = slot_c;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Randomized self-checking bench for tdm_demux_1to4; runs SYNC_CHECK=1 and SYNC_CHECK=0 side by side.
// Build with TDM_DEMUX_SHADOW_EN defined to check the shadow-register variant.
module tb_tdm_demux_1to4;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       frame_sync;

    logic [7:0] ch_a_o [2];
    logic [7:0] ch_b_o [2];
    logic [7:0] ch_c_o [2];
    logic [7:0] ch_d_o [2];
    logic [3:0] strobe_o [2];
    logic       fv_o [2];
    logic       se_o [2];
    logic [1:0] slot_o [2];
    logic [7:0] cnt_o [2];

    int n_tests = 0;
    int n_fail  = 0;

    tdm_demux_1to4 #(.WIDTH(8), .SYNC_CHECK(1), .CNT_W(8)) dut_chk (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .ch_a(ch_a_o[0]), .ch_b(ch_b_o[0]), .ch_c(ch_c_o[0]), .ch_d(ch_d_o[0]),
        .ch_strobe(strobe_o[0]), .frame_valid(fv_o[0]), .sync_err(se_o[0]),
        .slot(slot_o[0]), .frame_cnt(cnt_o[0])
    );

    tdm_demux_1to4 #(.WIDTH(8), .SYNC_CHECK(0), .CNT_W(8)) dut_free (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .ch_a(ch_a_o[1]), .ch_b(ch_b_o[1]), .ch_c(ch_c_o[1]), .ch_d(ch_d_o[1]),
        .ch_strobe(strobe_o[1]), .frame_valid(fv_o[1]), .sync_err(se_o[1]),
        .slot(slot_o[1]), .frame_cnt(cnt_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a frame buffer that fills beat by beat; model 0 requires sync on every frame.
    bit         m_strict [2] = '{1'b1, 1'b0};
    bit         m_synced [2];
    int         m_fill [2];
    logic [7:0] m_buf [2][4];
    logic [7:0] m_ch [2][4];
    logic [3:0] m_strb [2];
    logic       m_fv [2];
    logic       m_se [2];
    logic [7:0] m_cnt [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_synced[m] = 1'b0;
            m_fill[m]   = 0;
            m_strb[m]   = '0;
            m_fv[m]     = 1'b0;
            m_se[m]     = 1'b0;
            m_cnt[m]    = '0;
            for (int i = 0; i < 4; i++) begin
                m_buf[m][i] = '0;
                m_ch[m][i]  = '0;
            end
        end
    endtask

    task automatic model_push(input int m, input logic [7:0] d);
        m_buf[m][m_fill[m]] = d;
`ifndef TDM_DEMUX_SHADOW_EN
        m_ch[m][m_fill[m]] = d;
        m_strb[m] = 4'(1 << m_fill[m]);
`endif
        m_fill[m]++;
        if (m_fill[m] == 4) begin
            m_fv[m]  = 1'b1;
            m_cnt[m] = m_cnt[m] + 8'd1;
`ifdef TDM_DEMUX_SHADOW_EN
            for (int i = 0; i < 4; i++) m_ch[m][i] = m_buf[m][i];
            m_strb[m] = 4'hF;
`endif
            m_fill[m] = 0;
        end
    endtask

    task automatic model_beat(input int m, input logic v, input logic s, input logic [7:0] d);
        m_strb[m] = '0;
        m_fv[m]   = 1'b0;
        m_se[m]   = 1'b0;
        if (v) begin
            if (s) begin
                if (m_synced[m] && m_fill[m] != 0) m_se[m] = 1'b1;
                m_synced[m] = 1'b1;
                m_fill[m]   = 0;
                model_push(m, d);
            end else if (m_synced[m]) begin
                if (m_fill[m] == 0 && m_strict[m]) begin
                    m_se[m]     = 1'b1;
                    m_synced[m] = 1'b0;
                end else begin
                    model_push(m, d);
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("ch_a[%0d]", m), 32'(ch_a_o[m]), 32'(m_ch[m][0]));
            check($sformatf("ch_b[%0d]", m), 32'(ch_b_o[m]), 32'(m_ch[m][1]));
            check($sformatf("ch_c[%0d]", m), 32'(ch_c_o[m]), 32'(m_ch[m][2]));
            check($sformatf("ch_d[%0d]", m), 32'(ch_d_o[m]), 32'(m_ch[m][3]));
            check($sformatf("ch_strobe[%0d]", m), 32'(strobe_o[m]), 32'(m_strb[m]));
            check($sformatf("frame_valid[%0d]", m), 32'(fv_o[m]), 32'(m_fv[m]));
            check($sformatf("sync_err[%0d]", m), 32'(se_o[m]), 32'(m_se[m]));
            check($sformatf("slot[%0d]", m), 32'(slot_o[m]), m_synced[m] ? 32'(m_fill[m]) : 32'd0);
            check($sformatf("frame_cnt[%0d]", m), 32'(cnt_o[m]), 32'(m_cnt[m]));
        end
    endtask

    // Called just after a falling edge: drive, let one rising edge pass, check on the next falling edge.
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        for (int m = 0; m < 2; m++) model_beat(m, v, s, d);
        @(negedge clk);
        compare_all();
    endtask

    task automatic frame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] d3);
        step(1'b1, 1'b1, d0);
        step(1'b1, 1'b0, d1);
        step(1'b1, 1'b0, d2);
        step(1'b1, 1'b0, d3);
    endtask

    task automatic async_reset();
        rst       = 1'b1;
        din_valid = 1'b0;
        model_reset();
        #2;
        compare_all();
        @(negedge clk);
        compare_all();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;

        // basic frame, then idle cycles with a stray unqualified sync
        frame(8'h11, 8'h22, 8'h33, 8'h44);
        step(1'b0, 1'b1, 8'hEE);
        step(1'b0, 1'b0, 8'h00);

        // reset after slots 0,1, then a clean frame
        step(1'b1, 1'b1, 8'hA0);
        step(1'b1, 1'b0, 8'hA1);
        async_reset();
        frame(8'h51, 8'h52, 8'h53, 8'h54);

        // unsynced beats from IDLE are dropped
        async_reset();
        step(1'b1, 1'b0, 8'h77);
        step(1'b1, 1'b0, 8'h78);
        frame(8'h61, 8'h62, 8'h63, 8'h64);

        // sync on slot 2 restarts the frame
        step(1'b1, 1'b1, 8'h01);
        step(1'b1, 1'b0, 8'h02);
        step(1'b1, 1'b1, 8'h03);
        step(1'b1, 1'b0, 8'h04);
        step(1'b1, 1'b0, 8'h05);
        step(1'b1, 1'b0, 8'h06);

        // second frame without sync: strict instance drops out, free-running one accepts it
        frame(8'h21, 8'h22, 8'h23, 8'h24);
        step(1'b1, 1'b0, 8'h31);
        step(1'b1, 1'b0, 8'h32);
        step(1'b1, 1'b0, 8'h33);
        step(1'b1, 1'b0, 8'h34);

        // long run of clean frames with random gaps: frame_cnt wraps
        async_reset();
        for (int f = 0; f < 260; f++) begin
            for (int k = 0; k < 4; k++) begin
                int gaps;
                gaps = int'($urandom_range(0, 2));
                for (int g = 0; g < gaps; g++) step(1'b0, 1'($urandom % 2), 8'($urandom));
                step(1'b1, k == 0, 8'($urandom));
            end
        end

        // unconstrained traffic with random sync placement
        for (int i = 0; i < 2000; i++) begin
            step(($urandom % 4) != 0, ($urandom % 5) == 0, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
